// File: rtl/dmux4_dispatch_pkg.sv
// Shared types and constants for the dmux4_dispatch front-end.
// Holds the FSM encoding, steering modes and default widths.
package dmux4_dispatch_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } mode_t;

  // Round-robin pointer step; wraps 3 -> 0 through natural 2-bit overflow.
  function automatic logic [1:0] next_rr(input logic [1:0] ptr);
    return ptr + 2'd1;
  endfunction

endpackage

// File: rtl/dmux4_dispatch_dmux.sv
// 16-bit 4-way demultiplexer: routes data to one of four buses, zero elsewhere.
// sel[1] picks the pair (out1/out2 vs out3/out4), sel[0] picks within the pair.
module dmux4_dispatch_dmux #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4
);

  logic [WIDTH-1:0] pair [2];
  logic [WIDTH-1:0] lane [4];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pair
      assign pair[gi] = (sel[1] == 1'(gi)) ? data : '0;
    end
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = (sel[0] == 1'(gi % 2)) ? pair[gi / 2] : '0;
    end
  endgenerate

  assign out1 = lane[0];
  assign out2 = lane[1];
  assign out3 = lane[2];
  assign out4 = lane[3];

endmodule

// File: rtl/dmux4_dispatch.sv
// One-entry dispatcher: accepts words over valid/ready and steers each to one of
// four destinations (addressed or round-robin), with saturating delivery counters.
module dmux4_dispatch
  import dmux4_dispatch_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  input  logic             mode,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hold_data_reg, hold_data_next;
  logic [1:0]       hold_dest_reg, hold_dest_next;
  logic [1:0]       rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0] cnt_val [4];

  logic full;
  logic accept;
  logic deliver;

  assign full = (state_reg == ST_FULL);

  // Combinational ready lets a delivery and a new accept share one cycle.
  assign in_ready = reset_n & ~flush & (~full | out_ready[hold_dest_reg]);
  assign accept   = in_valid & in_ready;
  assign deliver  = full & out_ready[hold_dest_reg] & ~flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_EMPTY;
      hold_data_reg <= '0;
      hold_dest_reg <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      hold_data_reg <= hold_data_next;
      hold_dest_reg <= hold_dest_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hold_data_next = hold_data_reg;
    hold_dest_next = hold_dest_reg;
    rr_ptr_next    = rr_ptr_reg;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      if (deliver) begin
        state_next = ST_EMPTY;
      end
      if (accept) begin
        state_next     = ST_FULL;
        hold_data_next = in_data;
        if (mode == MODE_RR) begin
          hold_dest_next = rr_ptr_reg;
          rr_ptr_next    = next_rr(rr_ptr_reg);
        end else begin
          hold_dest_next = in_dest;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dest
      logic [CNT_W-1:0] cnt_reg;

      assign out_valid[gi] = full & (hold_dest_reg == 2'(gi));
      assign cnt_val[gi]   = cnt_reg;

      // Clear wins over a same-cycle delivery.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else if (clr_cnt) begin
          cnt_reg <= '0;
        end else if (deliver && (hold_dest_reg == 2'(gi)) && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign cnt_out = cnt_val[cnt_sel];

  dmux4_dispatch_dmux #(
    .WIDTH(WIDTH)
  ) u_dmux (
    .data(full ? hold_data_reg : '0),
    .sel (hold_dest_reg),
    .out1(out1),
    .out2(out2),
    .out3(out3),
    .out4(out4)
  );

endmodule

// File: doc/dmux4_dispatch.md
Name: dmux4_dispatch

Overview:
- Sequenced front-end for the 4-way, 16-bit demultiplexer datapath.
- Accepts 16-bit words over a valid/ready handshake and holds each word in a one-entry register.
- Steers the held word to one of four destinations, chosen either by an explicit address or by round-robin, with per-destination valid/ready.
- Keeps saturating per-destination delivery counters for the CPU-side status path.

Parameters:
- WIDTH, 16, data word width.
- CNT_W, 8, width of each per-destination delivery counter.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  source presents a word.
- in_ready  out  1  dispatcher can accept a word this cycle.
- in_data  in  WIDTH  word to dispatch.
- in_dest  in  2  destination index when mode=0.
- mode  in  1  0 = addressed (in_dest), 1 = round-robin.
- flush  in  1  synchronous drop of the held word.
- clr_cnt  in  1  synchronous clear of all counters.
- out1, out2, out3, out4  out  WIDTH  destination data buses 0..3.
- out_valid  out  4  one-hot; bit i means out(i+1) carries a valid word.
- out_ready  in  4  per-destination ready.
- cnt_sel  in  2  counter read select.
- cnt_out  out  CNT_W  counter[cnt_sel], combinational read.

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-low.
- While reset_n=0:
  - state=EMPTY, rr_ptr=0, hold_data=0, hold_dest=0, all counters=0.
  - out1..out4=0, out_valid=0, in_ready=0.
  - cnt_out=0.
- FSM has two states, EMPTY and FULL.
- Combinational outputs:
  - in_ready = reset_n & ~flush & (EMPTY | out_ready[hold_dest]).
  - The out_ready→in_ready path is combinational by design.
  - out_valid[i] = FULL & (hold_dest==i).
  - out(i+1) = hold_data when out_valid[i], else 0. This matches the demux's zero-on-unselected rule.
- Accept = in_valid & in_ready.
  - Destination latched on accept: mode ? rr_ptr : in_dest.
  - In mode 1, rr_ptr advances by 1 mod 4 on each accept, wrapping 3→0.
  - In mode 0, rr_ptr holds its value.
- Deliver = FULL & out_ready[hold_dest].
  - On deliver, counter[hold_dest] increments and saturates at 2^CNT_W-1.
- State transitions:
  - EMPTY & accept → FULL.
  - FULL & deliver & ~accept → EMPTY.
  - FULL & deliver & accept → FULL with the new word. This gives back-to-back throughput of 1 word/cycle.
  - FULL & ~deliver → FULL. Word and destination are stable; out_valid stays high until taken, with no withdrawal.
- Latency: a word accepted at edge N appears on the outputs from cycle N+1.
- flush=1:
  - Next state EMPTY, held word discarded with no counter increment.
  - in_ready=0 that cycle; rr_ptr unchanged.
  - flush has priority over deliver and accept.
- clr_cnt=1: all counters become 0 at the edge. A deliver in the same cycle is lost, so the counter reads 0.
- A mode change takes effect on the next accept only; the held word is unaffected.
- Ready bits for non-selected destinations are ignored.
- Reset asserted mid-operation: immediate return to reset values; the held word is lost.

Decomposition:
- Shared package/header holds:
  - state encoding constants ST_EMPTY=1'b0, ST_FULL=1'b1.
  - MODE_ADDR=0, MODE_RR=1.
  - default WIDTH/CNT_W.
- One natural sub-module: the existing 16-bit 4-way demux (DMux4Way16).
  - Instantiated with in=hold_data gated by FULL, and sel=hold_dest.
  - It drives out1..out4.
  - sel[1] selects the pair (out1/out2 vs out3/out4); sel[0] selects within the pair.
- Counters and the FSM stay in dmux4_dispatch.

Test Plan:
- Reset check: with reset_n=0 for 3 cycles, then released → out_valid=0000 and out1..4=0 throughout; in_ready=0 during reset and 1 in the first cycle after release; cnt_out=0 for all cnt_sel.
- Addressed single word: mode=0, in_dest=2, in_data=16'hBEEF, out_ready=0000 → out3=BEEF and out_valid=0100 from the next cycle, held 5 cycles, in_ready=0. Then out_ready[2]=1 → EMPTY next cycle, counter[2]=1, others 0.
- Round-robin streaming: mode=1, out_ready=1111, in_valid held for 6 words 16'h0001..0006 → one word per cycle to destinations 0,1,2,3,0,1; counters read 2,2,1,1; rr_ptr wraps correctly.
- Back-to-back under stall: word A to dest 1 with out_ready[1]=0 and word B waiting → B not accepted. Raising out_ready[1] delivers A and accepts B in the same cycle; B visible the next cycle.
- Flush and clear: FULL holding 16'h1234 to dest 3, flush=1 with out_ready[3]=1 → EMPTY, counter[3] unchanged, in_ready=0 during flush. Separately, 255 deliveries to dest 0 followed by 2 more → counter[0] saturates at 255. clr_cnt → 0.
- Async reset mid-transfer: FULL to dest 0, reset_n dropped between clock edges → out_valid and out1 go to 0 immediately, without waiting for an edge.
